// File: rtl/fixedp_div.sv
// Signed fixed-point divider: restoring division, one quotient bit per clock, truncated toward zero.
// Saturates to the output range (ovf) and returns a signed full-scale result on a zero divisor (div_zero).
module fixedp_div #(
  parameter int WI1 = 4,
  parameter int WF1 = 16,
  parameter int WI2 = 4,
  parameter int WF2 = 16,
  parameter int WIO = WI1 + WF2,
  parameter int WFO = WF1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WI1+WF1-1:0]   in1,
  input  logic [WI2+WF2-1:0]   in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIO+WFO-1:0]   out,
  output logic                 ovf,
  output logic                 div_zero
);

  localparam int W1 = WI1 + WF1;
  localparam int W2 = WI2 + WF2;
  localparam int WO = WIO + WFO;
  localparam int S  = WFO + WF2 - WF1;
  localparam int DW = W1 + S;
  localparam int RW = W2 + 1;
  localparam int CW = $clog2(DW + 1);
  localparam int QW = ((DW > WO) ? DW : WO) + 1;

  localparam logic [QW-1:0] LIM_POS = (QW'(1) << (WO - 1)) - QW'(1);
  localparam logic [QW-1:0] LIM_NEG = QW'(1) << (WO - 1);
  localparam logic [WO-1:0] OUT_MAX = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] OUT_MIN = {1'b1, {(WO-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] num;   // dividend bits shift out the top, quotient bits shift in at the bottom
  logic [RW-1:0] rem;
  logic [W2-1:0] den;
  logic          neg;
  logic          zpend;
  logic          zneg;

  // Unsigned magnitudes keep the most-negative operand exact
  logic [W1-1:0] mag1;
  logic [W2-1:0] mag2;
  logic [DW-1:0] num_ld;
  assign mag1   = in1[W1-1] ? (~in1 + W1'(1)) : in1;
  assign mag2   = in2[W2-1] ? (~in2 + W2'(1)) : in2;
  assign num_ld = DW'(mag1) << S;

  logic [RW:0]   rem_sh;
  logic [RW:0]   trial;
  logic          ge;
  logic [RW-1:0] rem_nx;
  logic [DW-1:0] num_nx;
  assign rem_sh = {rem, num[DW-1]};
  assign trial  = rem_sh - (RW+1)'(den);
  assign ge     = rem_sh >= (RW+1)'(den);
  assign rem_nx = ge ? RW'(trial) : RW'(rem_sh);
  assign num_nx = {num[DW-2:0], ge};

  // Negative results may reach one step further than positive ones
  logic [QW-1:0] q_ext;
  logic          sat;
  logic [WO-1:0] q_out;
  logic [WO-1:0] res;
  assign q_ext = QW'(num_nx);
  assign sat   = neg ? (q_ext > LIM_NEG) : (q_ext > LIM_POS);
  assign q_out = WO'(num_nx);
  assign res   = sat ? (neg ? OUT_MIN : OUT_MAX) : (neg ? (~q_out + WO'(1)) : q_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      num       <= '0;
      rem       <= '0;
      den       <= '0;
      neg       <= 1'b0;
      zpend     <= 1'b0;
      zneg      <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
      div_zero  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (zpend) begin
            zpend     <= 1'b0;
            state     <= DONE;
            out_valid <= 1'b1;
            out       <= zneg ? OUT_MIN : OUT_MAX;
            ovf       <= 1'b0;
            div_zero  <= 1'b1;
          end else if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (in2 == '0) begin
              zpend <= 1'b1;
              zneg  <= in1[W1-1];
            end else begin
              state <= BUSY;
              cnt   <= CW'(DW);
              num   <= num_ld;
              rem   <= '0;
              den   <= mag2;
              neg   <= in1[W1-1] ^ in2[W2-1];
            end
          end
        end
        BUSY: begin
          num <= num_nx;
          rem <= rem_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out       <= res;
            ovf       <= sat;
            div_zero  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
